lpcm_tdm_driver: RTL and testbench
==================================

Name: lpcm_tdm_driver

Overview:
- Parametrised successor to the single-channel LPCM active path.
- Accepts multi-channel frame items from a sequencer through a valid/ready handshake and buffers them in an internal FIFO.
- Serialises each item onto a TDM LPCM line (sclk/fsync/sdata), echoes each transmitted item as a response, and counts underruns.
- Raises a sticky done after NUM_ITEMS frames. Sits between the sequencer and the LPCM interface inside the active agent.

Parameters:
- NUM_CH, 2, channels per frame (>=1)
- SAMPLE_W, 16, bits per channel sample (>=2)
- CLK_DIV, 4, clk cycles per serial bit (even, >=2)
- FIFO_DEPTH, 4, item FIFO entries (power of 2, >=2)
- NUM_ITEMS, 16, FIFO-sourced frames to transmit before done asserts (>=1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_en  in  1  request valid
- req  in  NUM_CH*SAMPLE_W  frame item; channel k in req[k*SAMPLE_W +: SAMPLE_W]
- req_ready  out  1  FIFO can accept
- rsp_en  out  1  one-cycle pulse: a FIFO-sourced frame finished transmission
- rsp  out  NUM_CH*SAMPLE_W  the item just transmitted
- sclk  out  1  serial bit clock
- fsync  out  1  frame sync
- sdata  out  1  serial data
- underrun_cnt  out  16  zero-filled frames sent, saturating at 16'hFFFF
- done  out  1  sticky; NUM_ITEMS frames completed

Behaviour:
- Reset (asynchronous assertion, synchronous release): all outputs are 0 except req_ready=1. FIFO is empty, state is IDLE, all counters are 0. Reset mid-frame aborts the frame immediately; no rsp_en is issued for it.
- Handshake: a push occurs on a rising edge with req_en && req_ready. req_ready = !full, computed from the registered count. At full, a push is refused even if a pop happens on the same edge. A simultaneous push and pop at non-full leaves the count unchanged.
- FRAME_BITS = NUM_CH*SAMPLE_W. Bit order: channel 0 first, then 1..NUM_CH-1, each MSB first.
- State machine:
  - IDLE: sclk, fsync and sdata are held at 0. On an edge where the FIFO is non-empty: pop, load the shift register, set div=0 and bit=0, go to RUN. The first MSB appears on sdata the cycle after that edge, which is 2 edges after the first push.
  - RUN: runs freely and never returns to IDLE except via reset.
- Bit timing:
  - div counts 0..CLK_DIV-1.
  - sclk is registered: 0 for div < CLK_DIV/2, 1 otherwise.
  - sdata and fsync change only when div=0, so they are stable at the sclk rising edge.
  - fsync=1 for the whole bit period of bit 0, and 0 otherwise.
- Frame boundary (div=CLK_DIV-1 and bit=FRAME_BITS-1): on the next edge, the next frame starts with no gap.
  - If the FIFO is non-empty: pop.
  - If empty: load all-zero data, and underrun_cnt += 1 (saturating).
- Response:
  - For a frame sourced from the FIFO, rsp_en=1 for exactly one cycle, the cycle after its last bit period, i.e. concurrent with the next frame's bit 0.
  - rsp holds that item and stays stable until the next rsp_en.
  - Zero-fill frames produce no rsp_en.
- done: set in the same cycle as the NUM_ITEMS-th rsp_en; stays 1 until reset. Transmission continues after done.
- Frame period = FRAME_BITS*CLK_DIV clk cycles.

Test Plan (NUM_CH=2, SAMPLE_W=16, CLK_DIV=4, FIFO_DEPTH=4, NUM_ITEMS=16 unless stated; frame = 128 cycles):
- Single item: push req=32'hA5A5_1234 -> sdata bits 0x1234 MSB-first, then 0xA5A5; fsync=1 for the first 4 cycles only; sclk pattern 0,0,1,1. rsp_en pulses 128 cycles after the first bit with rsp=32'hA5A5_1234.
- Underrun: after the single item, no further pushes -> following frames have sdata=0 and fsync still pulses; underrun_cnt reads 1, 2, 3 at successive frame starts; no rsp_en.
- Backpressure: hold req_en=1 with distinct items -> req_ready drops once 4 entries are held; each further acceptance occurs exactly 128 cycles apart. All items are transmitted in push order with no loss or duplication.
- done: stream 16 items back to back -> done rises in the same cycle as the 16th rsp_en; underrun_cnt=0 throughout. done remains 1 through a subsequent underrun frame.
- Reset mid-frame: drop rst_n at bit 10 of a frame -> sclk, fsync, sdata, rsp_en and underrun_cnt are 0 immediately, req_ready=1. After release with no push, sclk stays 0 for 200 cycles.
- Config variant NUM_CH=4, SAMPLE_W=8, CLK_DIV=2: push 32'h0403_0201 -> sdata sequence 0x01, 0x02, 0x03, 0x04 MSB-first; frame = 64 cycles; rsp_en 64 cycles after the first bit.

Source files
------------

// File: rtl/lpcm_tdm_driver_if.sv
// Sequencer-facing handshake bundle for lpcm_tdm_driver: request push path and
// the echo of each transmitted item.
interface lpcm_tdm_driver_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16
);
  logic                       req_en;
  logic [NUM_CH*SAMPLE_W-1:0] req;
  logic                       req_ready;
  logic                       rsp_en;
  logic [NUM_CH*SAMPLE_W-1:0] rsp;

  modport master (output req_en, output req, input req_ready, input rsp_en, input rsp);
  modport slave  (input req_en, input req, output req_ready, output rsp_en, output rsp);
endinterface

// File: rtl/lpcm_tdm_driver.sv
// Buffers multi-channel frame items in a FIFO and serialises them onto a TDM
// LPCM line, zero-filling and counting underruns when the FIFO runs dry.
module lpcm_tdm_driver #(
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 16,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_ITEMS  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lpcm_tdm_driver_if.slave        bus,
  output logic                    sclk,
  output logic                    fsync,
  output logic                    sdata,
  output logic [15:0]             underrun_cnt,
  output logic                    done
);
  localparam int FRAME_BITS = NUM_CH * SAMPLE_W;
  localparam int DIV_W      = $clog2(CLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_ITEMS - 1);

  typedef enum logic {IDLE, RUN} state_e;
  typedef logic [FRAME_BITS-1:0] item_t;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  item_t                shift_q, shift_d;
  item_t                cur_item_q, cur_item_d;
  logic                 cur_fifo_q, cur_fifo_d;
  logic                 sclk_q, sclk_d;
  logic                 fsync_q, fsync_d;
  logic                 sdata_q, sdata_d;
  logic                 rsp_en_q, rsp_en_d;
  item_t                rsp_q, rsp_d;
  logic [15:0]          und_q, und_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     rsp_cnt_q, rsp_cnt_d;

  item_t                mem_q [FIFO_DEPTH];
  item_t                mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_q, wr_d;
  logic [PTR_W-1:0]     rd_q, rd_d;
  logic [PTR_W:0]       count_q, count_d;

  logic                 full, empty, push, pop, load;
  item_t                head, load_item;

  // Channel 0 is moved to the top so a plain left shift emits ch0..chN-1, each MSB first.
  function automatic item_t serial_order(input item_t it);
    item_t s;
    s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      s[(NUM_CH-1-c)*SAMPLE_W +: SAMPLE_W] = it[c*SAMPLE_W +: SAMPLE_W];
    end
    return s;
  endfunction

  assign full  = (count_q == FIFO_FULL);
  assign empty = (count_q == '0);
  assign push  = bus.req_en && !full;
  assign head  = mem_q[rd_q];

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    cur_item_d = cur_item_q;
    cur_fifo_d = cur_fifo_q;
    rsp_en_d   = 1'b0;
    rsp_d      = rsp_q;
    und_d      = und_q;
    done_d     = done_q;
    rsp_cnt_d  = rsp_cnt_q;
    pop        = 1'b0;
    load       = 1'b0;
    load_item  = '0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          load      = 1'b1;
          load_item = head;
          state_d   = RUN;
          div_d     = '0;
          bit_d     = '0;
        end
      end
      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            load  = 1'b1;
            if (cur_fifo_q) begin
              rsp_en_d = 1'b1;
              rsp_d    = cur_item_q;
              if (!done_q) begin
                if (rsp_cnt_q == CNT_LAST) done_d = 1'b1;
                else rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
              end
            end
            if (!empty) begin
              pop       = 1'b1;
              load_item = head;
            end else if (und_q != 16'hFFFF) begin
              und_d = und_q + 16'd1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d    = serial_order(load_item);
      cur_item_d = load_item;
      cur_fifo_d = pop;
    end

    // Line outputs follow the next-state counters so they register in step with them.
    sclk_d  = (state_d == RUN) && (div_d >= DIV_HALF);
    fsync_d = (state_d == RUN) && (bit_d == '0);
    sdata_d = (state_d == RUN) && shift_d[FRAME_BITS-1];
  end

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = bus.req;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
    else if (!push && pop) count_d = count_q - (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      cur_item_q <= '0;
      cur_fifo_q <= 1'b0;
      sclk_q     <= 1'b0;
      fsync_q    <= 1'b0;
      sdata_q    <= 1'b0;
      rsp_en_q   <= 1'b0;
      rsp_q      <= '0;
      und_q      <= '0;
      done_q     <= 1'b0;
      rsp_cnt_q  <= '0;
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      cur_item_q <= cur_item_d;
      cur_fifo_q <= cur_fifo_d;
      sclk_q     <= sclk_d;
      fsync_q    <= fsync_d;
      sdata_q    <= sdata_d;
      rsp_en_q   <= rsp_en_d;
      rsp_q      <= rsp_d;
      und_q      <= und_d;
      done_q     <= done_d;
      rsp_cnt_q  <= rsp_cnt_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
    end
  end

  assign bus.req_ready = !full;
  assign bus.rsp_en    = rsp_en_q;
  assign bus.rsp       = rsp_q;
  assign sclk          = sclk_q;
  assign fsync         = fsync_q;
  assign sdata         = sdata_q;
  assign underrun_cnt  = und_q;
  assign done          = done_q;
endmodule

// File: tb/tb_lpcm_tdm_driver.sv
// Self-checking bench for lpcm_tdm_driver: a frame-level reference model tracks
// the expected line, handshake and status outputs every cycle.
module tb_lpcm_tdm_driver;
  localparam int NUM_CH     = 2;
  localparam int SAMPLE_W   = 16;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int NUM_ITEMS  = 16;
  localparam int FRAME_BITS = NUM_CH * SAMPLE_W;
  localparam int FRAME_CYC  = FRAME_BITS * CLK_DIV;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        rst2_n = 1'b0;
  logic        sclk, fsync, sdata, done;
  logic [15:0] underrun_cnt;
  logic        sclk2, fsync2, sdata2, done2;
  logic [15:0] underrun_cnt2;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  bit          chk_en = 1'b0;

  lpcm_tdm_driver_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W)) bus ();
  lpcm_tdm_driver_if #(.NUM_CH(4), .SAMPLE_W(8)) bus2 ();

  lpcm_tdm_driver #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .CLK_DIV(CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH), .NUM_ITEMS(NUM_ITEMS)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .sclk(sclk), .fsync(fsync), .sdata(sdata),
    .underrun_cnt(underrun_cnt), .done(done)
  );

  lpcm_tdm_driver #(
    .NUM_CH(4), .SAMPLE_W(8), .CLK_DIV(2), .FIFO_DEPTH(4), .NUM_ITEMS(16)
  ) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2.slave),
    .sclk(sclk2), .fsync(fsync2), .sdata(sdata2),
    .underrun_cnt(underrun_cnt2), .done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: FIFO as a queue, frame position as a single cycle index.
  logic [FRAME_BITS-1:0] m_q[$];
  logic [FRAME_BITS-1:0] m_cur = '0;
  logic [FRAME_BITS-1:0] m_rsp = '0;
  bit m_run = 0, m_cur_fifo = 0, m_rsp_en = 0, m_done = 0;
  int m_phase = 0, m_und = 0, m_rsp_cnt = 0;

  function automatic bit serialBit(input logic [FRAME_BITS-1:0] item, input int n);
    int ch = n / SAMPLE_W;
    int b  = SAMPLE_W - 1 - (n % SAMPLE_W);
    return item[ch*SAMPLE_W + b];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_cur = '0; m_rsp = '0; m_run = 0; m_cur_fifo = 0; m_rsp_en = 0;
      m_done = 0; m_phase = 0; m_und = 0; m_rsp_cnt = 0;
    end else begin
      bit acc;
      logic [FRAME_BITS-1:0] din;
      acc = bus.req_en && (m_q.size() < FIFO_DEPTH);
      din = bus.req;
      m_rsp_en = 0;
      if (!m_run) begin
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front(); m_cur_fifo = 1; m_run = 1; m_phase = 0;
        end
      end else if (m_phase == FRAME_CYC - 1) begin
        if (m_cur_fifo) begin
          m_rsp_en = 1; m_rsp = m_cur;
          if (!m_done) begin
            m_rsp_cnt++;
            if (m_rsp_cnt == NUM_ITEMS) m_done = 1;
          end
        end
        m_phase = 0;
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front(); m_cur_fifo = 1;
        end else begin
          m_cur = '0; m_cur_fifo = 0;
          if (m_und < 65535) m_und++;
        end
      end else begin
        m_phase++;
      end
      if (acc) m_q.push_back(din);
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      checkOutput("sclk", 32'(sclk), 32'(m_run && ((m_phase % CLK_DIV) >= CLK_DIV/2)));
      checkOutput("fsync", 32'(fsync), 32'(m_run && (m_phase < CLK_DIV)));
      checkOutput("sdata", 32'(sdata), 32'(m_run && serialBit(m_cur, m_phase / CLK_DIV)));
      checkOutput("req_ready", 32'(bus.req_ready), 32'(m_q.size() < FIFO_DEPTH));
      checkOutput("rsp_en", 32'(bus.rsp_en), 32'(m_rsp_en));
      checkOutput("rsp", bus.rsp, m_rsp);
      checkOutput("underrun_cnt", 32'(underrun_cnt), 32'(m_und));
      checkOutput("done", 32'(done), 32'(m_done));
    end
  end

  task automatic applyStimulus(input bit en, input logic [31:0] data);
    @(negedge clk);
    bus.req_en = en;
    bus.req    = data;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitHigh(input string tag, ref logic sig, input int budget);
    int n = 0;
    while (sig !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sig !== 1'b1) checkOutput(tag, 32'(sig), 32'd1);
  endtask

  initial begin
    int t0, t1, t2, n, acc;
    bit will, und_before;
    int acc_t[$];
    logic [31:0] word;

    bus.req_en = 0; bus.req = '0; bus2.req_en = 0; bus2.req = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_sclk", 32'(sclk), 0);
    checkOutput("rst_fsync", 32'(fsync), 0);
    checkOutput("rst_sdata", 32'(sdata), 0);
    checkOutput("rst_rsp_en", 32'(bus.rsp_en), 0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 1);
    checkOutput("rst_underrun", 32'(underrun_cnt), 0);
    checkOutput("rst_done", 32'(done), 0);
    rst_n = 1; rst2_n = 1; chk_en = 1;

    // Single item, its exact serial image, response latency and underruns after it.
    applyStimulus(1, 32'hA5A5_1234);
    t0 = cyc;
    applyStimulus(0, '0);
    waitHigh("fsync_timeout", fsync, 50);
    t1 = cyc;
    checkOutput("first_bit_latency", 32'(t1 - t0), 32'd2);
    word = '0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      word[FRAME_BITS-1-b] = sdata;
      repeat (CLK_DIV) @(negedge clk);
    end
    checkOutput("serial_word", word, 32'h1234_A5A5);
    waitHigh("rsp_timeout", bus.rsp_en, 300);
    t2 = cyc;
    checkOutput("rsp_latency", 32'(t2 - t1), 32'(FRAME_CYC));
    checkOutput("rsp_item", bus.rsp, 32'hA5A5_1234);
    for (int k = 1; k <= 3; k++) begin
      checkOutput("underrun_step", 32'(underrun_cnt), 32'(k));
      repeat (FRAME_CYC) @(negedge clk);
    end

    // Backpressure with distinct items, then done after NUM_ITEMS frames.
    resetDut();
    acc = 0; n = 0;
    applyStimulus(1, {$urandom_range(0, 65535), 16'(acc)});
    while (acc < NUM_ITEMS && n < 5000) begin
      will = bus.req_ready;
      if (will) begin
        acc++;
        acc_t.push_back(cyc);
      end
      @(negedge clk);
      n++;
      if (will) bus.req = {16'($urandom_range(0, 65535)), 16'(acc)};
    end
    bus.req_en = 0;
    checkOutput("accept_count", 32'(acc), 32'(NUM_ITEMS));
    for (int i = FIFO_DEPTH + 2; i < acc_t.size(); i++)
      checkOutput("accept_gap", 32'(acc_t[i] - acc_t[i-1]), 32'(FRAME_CYC));
    n = 0; und_before = 0;
    while (done !== 1'b1 && n < 4000) begin
      if (underrun_cnt != 0) und_before = 1;
      @(negedge clk);
      n++;
    end
    checkOutput("done_timeout", 32'(done), 1);
    checkOutput("done_with_rsp", 32'(bus.rsp_en), 1);
    checkOutput("underrun_before_done", 32'(und_before), 0);
    repeat (2 * FRAME_CYC) @(negedge clk);
    checkOutput("done_sticky", 32'(done), 1);
    checkOutput("underrun_after_done", 32'(underrun_cnt), 3);

    // Random traffic against the model.
    resetDut();
    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 2) == 0, $urandom);
    applyStimulus(0, '0);

    // Reset during bit 10 of a frame.
    resetDut();
    applyStimulus(1, $urandom);
    applyStimulus(0, '0);
    waitHigh("fsync_timeout2", fsync, 50);
    repeat (10 * CLK_DIV) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_sclk", 32'(sclk), 0);
    checkOutput("midrst_fsync", 32'(fsync), 0);
    checkOutput("midrst_sdata", 32'(sdata), 0);
    checkOutput("midrst_rsp_en", 32'(bus.rsp_en), 0);
    checkOutput("midrst_underrun", 32'(underrun_cnt), 0);
    checkOutput("midrst_req_ready", 32'(bus.req_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    t0 = 0; t1 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sclk !== 1'b0) t0++;
      if (bus.rsp_en !== 1'b0) t1++;
    end
    checkOutput("post_rst_sclk_high", 32'(t0), 0);
    checkOutput("post_rst_rsp_en", 32'(t1), 0);

    // Four 8-bit channels at CLK_DIV=2.
    @(negedge clk);
    bus2.req_en = 1; bus2.req = 32'h0403_0201;
    @(negedge clk);
    bus2.req_en = 0;
    waitHigh("fsync2_timeout", fsync2, 50);
    t1 = cyc;
    word = '0;
    for (int b = 0; b < 32; b++) begin
      word[31-b] = sdata2;
      repeat (2) @(negedge clk);
    end
    checkOutput("serial_word_4ch", word, 32'h0102_0304);
    waitHigh("rsp2_timeout", bus2.rsp_en, 200);
    t2 = cyc;
    checkOutput("rsp_latency_4ch", 32'(t2 - t1), 32'd64);
    checkOutput("rsp_item_4ch", bus2.rsp, 32'h0403_0201);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
